// File: rtl/ahb_apb_bridge_pkg.sv
// Shared types, AHB encodings and address-phase helpers for the AHB-Lite to APB4 bridge.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  function automatic logic [3:0] gen_pstrb(input logic [2:0] hsize, input logic [1:0] addr);
    case (hsize)
      HSIZE_BYTE: gen_pstrb = 4'b0001 << addr;
      HSIZE_HALF: gen_pstrb = 4'b0011 << addr;
      default:    gen_pstrb = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] hsize, input logic [1:0] addr);
    case (hsize)
      HSIZE_HALF: is_misaligned = addr[0];
      HSIZE_WORD: is_misaligned = (addr != 2'b00);
      default:    is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_if.sv
// AHB-Lite slave port plus APB4 master port of the bridge, named from the bridge's point of view.
interface ahb_apb_bridge_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_PSLV       = 4,
  parameter int PSLV_ADDR_BITS = 12
);

  logic                           hsel_i;
  logic [31:0]                    haddr_i;
  logic [1:0]                     htrans_i;
  logic                           hwrite_i;
  logic [2:0]                     hsize_i;
  logic [DATA_WIDTH-1:0]          hwdata_i;
  logic                           hready_i;
  logic                           hreadyout_o;
  logic [DATA_WIDTH-1:0]          hrdata_o;
  logic                           hresp_o;

  logic [NUM_PSLV-1:0]            psel_o;
  logic                           penable_o;
  logic [PSLV_ADDR_BITS-1:0]      paddr_o;
  logic                           pwrite_o;
  logic [DATA_WIDTH-1:0]          pwdata_o;
  logic [DATA_WIDTH/8-1:0]        pstrb_o;
  logic [NUM_PSLV*DATA_WIDTH-1:0] prdata_i;
  logic [NUM_PSLV-1:0]            pready_i;
  logic [NUM_PSLV-1:0]            pslverr_i;

  modport slave (
    input  hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hwdata_i, hready_i,
    output hreadyout_o, hrdata_o, hresp_o,
    output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport master (
    output hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hwdata_i, hready_i,
    input  hreadyout_o, hrdata_o, hresp_o,
    input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o,
    output prdata_i, pready_i, pslverr_i
  );

endinterface

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave turning single peripheral-region transfers into APB4 transfers;
// decode faults and APB slave errors become a two-cycle AHB ERROR response.
module ahb_apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_PSLV       = 4,
  parameter int PSLV_ADDR_BITS = 12
) (
  input  logic             hclk_i,
  input  logic             hrst_i,
  ahb_apb_bridge_if.slave  bus
);

  localparam int IDX_W = 24 - PSLV_ADDR_BITS;

  state_e                    state_q;
  logic [NUM_PSLV-1:0]       psel_q;
  logic                      penable_q;
  logic [PSLV_ADDR_BITS-1:0] paddr_q;
  logic                      pwrite_q;
  logic [3:0]                pstrb_q;
  logic                      hreadyout_q;
  logic                      hresp_q;
  logic [DATA_WIDTH-1:0]     hrdata_q;

  logic [IDX_W-1:0]          addr_idx;
  logic                      accept;
  logic                      dec_err_d;
  logic [NUM_PSLV-1:0]       psel_d;
  logic [3:0]                pstrb_d;

  logic                      pready_sel;
  logic                      pslverr_sel;
  logic [DATA_WIDTH-1:0]     prdata_sel;

  logic                      unused_ok;

  assign addr_idx  = bus.haddr_i[23:PSLV_ADDR_BITS];
  assign accept    = bus.hsel_i && bus.hready_i && bus.htrans_i[1];
  assign dec_err_d = (32'(addr_idx) >= NUM_PSLV) || (bus.hsize_i > HSIZE_WORD) ||
                     is_misaligned(bus.hsize_i, bus.haddr_i[1:0]);
  assign psel_d    = NUM_PSLV'(1) << addr_idx;
  assign pstrb_d   = bus.hwrite_i ? gen_pstrb(bus.hsize_i, bus.haddr_i[1:0]) : 4'b0000;
  assign unused_ok = ^{bus.haddr_i[31:24], bus.htrans_i[0]};

  // psel_q is one-hot while a transfer is on APB and zero otherwise, so it doubles as the mux select.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int k = 0; k < NUM_PSLV; k++) begin
      if (psel_q[k]) begin
        pready_sel  = pready_sel  | bus.pready_i[k];
        pslverr_sel = pslverr_sel | bus.pslverr_i[k];
        prdata_sel  = prdata_sel  | bus.prdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk_i or posedge hrst_i) begin
    if (hrst_i) begin
      state_q     <= ST_IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= 4'b0000;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
    end else begin
      case (state_q)
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready_sel) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pstrb_q   <= 4'b0000;
            if (pslverr_sel) begin
              state_q <= ST_ERR1;
              hresp_q <= 1'b1;
            end else begin
              state_q     <= ST_DONE;
              hreadyout_q <= 1'b1;
              if (!pwrite_q) hrdata_q <= prdata_sel;
            end
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
        end
        default: begin
          // IDLE, DONE and ERR2 all sit in a completed data phase and may take a new address.
          state_q     <= ST_IDLE;
          psel_q      <= '0;
          penable_q   <= 1'b0;
          paddr_q     <= '0;
          pwrite_q    <= 1'b0;
          pstrb_q     <= 4'b0000;
          hresp_q     <= 1'b0;
          hreadyout_q <= 1'b1;
          if (accept) begin
            hreadyout_q <= 1'b0;
            if (dec_err_d) begin
              state_q <= ST_ERR1;
              hresp_q <= 1'b1;
            end else begin
              state_q  <= ST_SETUP;
              psel_q   <= psel_d;
              paddr_q  <= bus.haddr_i[PSLV_ADDR_BITS-1:0];
              pwrite_q <= bus.hwrite_i;
              pstrb_q  <= pstrb_d;
            end
          end
        end
      endcase
    end
  end

  assign bus.hreadyout_o = hreadyout_q;
  assign bus.hresp_o     = hresp_q;
  assign bus.hrdata_o    = hrdata_q;
  assign bus.psel_o      = psel_q;
  assign bus.penable_o   = penable_q;
  assign bus.paddr_o     = paddr_q;
  assign bus.pwrite_o    = pwrite_q;
  assign bus.pstrb_o     = pstrb_q;
  assign bus.pwdata_o    = bus.hwdata_i;

endmodule
